// File: rtl/prng_xoroshiro64s_pkg.sv
// Shared constants, helpers and state encoding for the xoroshiro64* generator/checker pair.
package prng_xoroshiro64s_pkg;

  localparam int unsigned A = 26;
  localparam int unsigned B = 9;
  localparam int unsigned C = 13;

  localparam logic [31:0] MUL = 32'h9E37_79BB;

  // Multiplicative inverse mod 2^32 by Newton iteration; x=m is already
  // correct to 3 bits and each round doubles that, so five rounds is plenty.
  function automatic logic [31:0] mul_inv32(input logic [31:0] m);
    logic [31:0] x;
    x = m;
    for (int i = 0; i < 5; i++) x = x * (32'd2 - m * x);
    return x;
  endfunction

  localparam logic [31:0] MUL_INV = mul_inv32(MUL);

  function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Inverse of u ^ (u << B): the shifted terms telescope out beyond bit 31.
  function automatic logic [31:0] unxs32(input logic [31:0] t);
    return t ^ (t << B) ^ (t << (2 * B)) ^ (t << (3 * B));
  endfunction

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_e;

endpackage

// File: rtl/xoroshiro64s_step.sv
// One combinational xoroshiro64* step plus the scrambled result of the new state.
module xoroshiro64s_step
  import prng_xoroshiro64s_pkg::*;
(
  input  logic [31:0] s0,
  input  logic [31:0] s1,
  output logic [31:0] n0,
  output logic [31:0] n1,
  output logic [31:0] result
);

  logic [31:0] x;

  // State advance followed by the output multiply (the long path of the checker)
  always_comb begin
    x      = s0 ^ s1;
    n0     = rotl32(s0, A) ^ x ^ (x << B);
    n1     = rotl32(x, C);
    result = n0 * MUL;
  end

endmodule

// File: rtl/prng_xoroshiro64s_checker.sv
// Receive-side xoroshiro64* checker: recovers generator state from two words,
// then regenerates the stream locally and counts matches and mismatches.
module prng_xoroshiro64s_checker
  import prng_xoroshiro64s_pkg::*;
#(
  parameter int ERR_LIMIT = 4,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [31:0]      i_data,
  output logic             o_locked,
  output logic             o_error,
  output logic [CNT_W-1:0] o_errCount,
  output logic [CNT_W-1:0] o_matchCount,
  output logic [31:0]      o_s0,
  output logic [31:0]      o_s1
);

  state_e             state_q, state_d;
  logic [31:0]        r0_q, r0_d;
  logic [31:0]        s0_q, s0_d;
  logic [31:0]        s1_q, s1_d;
  logic [7:0]         cons_q, cons_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic               error_q, error_d;

  logic [31:0]        n0, n1, exp_word;
  logic [31:0]        sa, sb, rx;

  xoroshiro64s_step u_step (
    .s0     (s0_q),
    .s1     (s1_q),
    .n0     (n0),
    .n1     (n1),
    .result (exp_word)
  );

  // Undo the output multiply on both words, then undo the s0 update to get x = s0^s1
  always_comb begin
    sa = r0_q * MUL_INV;
    sb = i_data * MUL_INV;
    rx = unxs32(sb ^ rotl32(sa, A));
  end

  // FSM next-state, state recovery/advance and saturating counters
  always_comb begin
    state_d     = state_q;
    r0_d        = r0_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    cons_d      = cons_q;
    err_cnt_d   = err_cnt_q;
    match_cnt_d = match_cnt_q;
    error_d     = error_q;

    if (i_cg) begin
      error_d = 1'b0;
      if (i_valid) begin
        unique case (state_q)
          HUNT: begin
            r0_d    = i_data;
            state_d = ACQ;
          end
          ACQ: begin
            s0_d    = sb;
            s1_d    = rotl32(rx, C);
            state_d = LOCKED;
          end
          LOCKED: begin
            // State advances regardless of the comparison outcome
            s0_d = n0;
            s1_d = n1;
            if (i_data == exp_word) begin
              match_cnt_d = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;
              cons_d      = 8'd0;
            end else begin
              error_d   = 1'b1;
              err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
              if (cons_q == 8'(ERR_LIMIT - 1)) begin
                cons_d  = 8'd0;
                state_d = HUNT;
              end else begin
                cons_d = cons_q + 8'd1;
              end
            end
          end
          default: state_d = HUNT;
        endcase
      end
      // Clear beats a same-cycle increment; the error pulse is left alone
      if (i_clear) begin
        err_cnt_d   = '0;
        match_cnt_d = '0;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= HUNT;
      r0_q        <= '0;
      s0_q        <= '0;
      s1_q        <= '0;
      cons_q      <= '0;
      err_cnt_q   <= '0;
      match_cnt_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      r0_q        <= r0_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      cons_q      <= cons_d;
      err_cnt_q   <= err_cnt_d;
      match_cnt_q <= match_cnt_d;
      error_q     <= error_d;
    end
  end

  assign o_locked     = (state_q == LOCKED);
  assign o_error      = error_q;
  assign o_errCount   = err_cnt_q;
  assign o_matchCount = match_cnt_q;
  assign o_s0         = s0_q;
  assign o_s1         = s1_q;

endmodule

// File: tb/tb_prng_xoroshiro64s_checker.sv
// Randomized bench: a golden xoroshiro64* generator feeds the checker; a
// high-level model (checker state == generator state once locked) predicts outputs.
module tb_prng_xoroshiro64s_checker;

  localparam int ERR_LIMIT = 4;
  localparam int CNT_W     = 10;
  localparam logic [CNT_W-1:0] MAXC = '1;

  logic             i_clk = 1'b0;
  logic             i_rst, i_cg, i_clear, i_valid;
  logic [31:0]      i_data;
  logic             o_locked, o_error;
  logic [CNT_W-1:0] o_errCount, o_matchCount;
  logic [31:0]      o_s0, o_s1;

  prng_xoroshiro64s_checker #(.ERR_LIMIT(ERR_LIMIT), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cg(i_cg), .i_clear(i_clear),
    .i_valid(i_valid), .i_data(i_data), .o_locked(o_locked), .o_error(o_error),
    .o_errCount(o_errCount), .o_matchCount(o_matchCount), .o_s0(o_s0), .o_s1(o_s1)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0, n_err = 0;

  // golden generator: g* is the state that produces the next word
  logic [31:0] g0, g1, golden, gp0, gp1;

  // model of the checker's observable behaviour
  int               m_mode;   // 0 hunting first word, 1 waiting second word, 2 locked
  int               m_cons;
  logic [CNT_W-1:0] m_ec, m_mc;
  logic             m_eo;
  logic [31:0]      m_s0, m_s1;

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  task automatic gen_word(output logic [31:0] w);
    logic [31:0] x;
    gp0 = g0; gp1 = g1;
    w = g0 * 32'h9E3779BB;
    x = g0 ^ g1;
    g0 = rl(g0, 26) ^ x ^ (x << 9);
    g1 = rl(x, 13);
    golden = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic check_outs();
    chk("locked", 32'(o_locked), 32'(m_mode == 2));
    chk("error", 32'(o_error), 32'(m_eo));
    chk("errCount", 32'(o_errCount), 32'(m_ec));
    chk("matchCount", 32'(o_matchCount), 32'(m_mc));
    chk("s0", o_s0, m_s0);
    chk("s1", o_s1, m_s1);
  endtask

  task automatic model_reset();
    m_mode = 0; m_cons = 0; m_ec = '0; m_mc = '0; m_eo = 1'b0; m_s0 = '0; m_s1 = '0;
  endtask

  // one clock with the given inputs, then update the model and compare
  task automatic cyc(input logic v, input logic [31:0] d, input logic clr, input logic cg);
    i_valid = v; i_data = d; i_clear = clr; i_cg = cg;
    @(posedge i_clk); #1;
    if (cg) begin
      m_eo = 1'b0;
      if (v) begin
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1) begin
          m_mode = 2; m_s0 = gp0; m_s1 = gp1;
        end else begin
          m_s0 = gp0; m_s1 = gp1;
          if (d == golden) begin
            if (m_mc != MAXC) m_mc++;
            m_cons = 0;
          end else begin
            m_eo = 1'b1;
            if (m_ec != MAXC) m_ec++;
            m_cons++;
            if (m_cons == ERR_LIMIT) begin m_mode = 0; m_cons = 0; end
          end
        end
      end
      if (clr) begin m_ec = '0; m_mc = '0; end
    end
    i_valid = 1'b0; i_clear = 1'b0; i_cg = 1'b1;
    check_outs();
  endtask

  task automatic word(input logic [31:0] mask, input logic clr);
    logic [31:0] w;
    gen_word(w);
    cyc(1'b1, w ^ mask, clr, 1'b1);
  endtask

  task automatic gap();
    cyc(1'b0, $urandom, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    #1;
    chk("rst_locked", 32'(o_locked), 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    chk("rst_errCount", 32'(o_errCount), 32'd0);
    chk("rst_matchCount", 32'(o_matchCount), 32'd0);
    chk("rst_s0", o_s0, 32'd0);
    chk("rst_s1", o_s1, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    i_rst = 1'b1; i_cg = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_data = '0;
    model_reset();
    @(posedge i_clk); #1;
    do_reset();

    // known vector: seed 1/0
    g0 = 32'd1; g1 = 32'd0;
    word(0, 0);
    word(0, 0);
    chk("vec_locked", 32'(o_locked), 32'd1);
    chk("vec_s0", o_s0, 32'h0400_0201);
    chk("vec_s1", o_s1, 32'h0000_2000);
    chk("vec_errCount", 32'(o_errCount), 32'd0);

    // long clean run with random gaps
    cyc(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) gap();
      word(0, 0);
    end
    chk("run_matchCount", 32'(o_matchCount), 32'd1000);

    // single bit flip
    cyc(1'b0, 0, 1'b1, 1'b1);
    word(32'h1, 0);
    chk("flip_error", 32'(o_error), 32'd1);
    for (int i = 0; i < 5; i++) word(0, 0);
    chk("flip_errCount", 32'(o_errCount), 32'd1);
    chk("flip_locked", 32'(o_locked), 32'd1);
    chk("flip_matchCount", 32'(o_matchCount), 32'd5);

    // ERR_LIMIT consecutive errors drop lock, two clean words relock
    cyc(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < ERR_LIMIT; i++) word($urandom | 32'h1, 0);
    chk("drop_locked", 32'(o_locked), 32'd0);
    chk("drop_errCount", 32'(o_errCount), 32'(ERR_LIMIT));
    word(0, 0);
    word(0, 0);
    chk("relock_locked", 32'(o_locked), 32'd1);
    chk("relock_errCount", 32'(o_errCount), 32'(ERR_LIMIT));

    // saturation, then clear racing an error
    for (int i = 0; i < 1030; i++) begin
      word(32'h1 << $urandom_range(0, 31), 0);
      word(0, 0);
    end
    chk("sat_errCount", 32'(o_errCount), 32'(MAXC));
    chk("sat_matchCount", 32'(o_matchCount), 32'(MAXC));
    word(32'h8000_0000, 1);
    chk("clr_errCount", 32'(o_errCount), 32'd0);
    chk("clr_error", 32'(o_error), 32'd1);

    // all-zero stream locks cleanly
    do_reset();
    g0 = 0; g1 = 0;
    for (int i = 0; i < 7; i++) word(0, 0);
    chk("zero_locked", 32'(o_locked), 32'd1);
    chk("zero_matchCount", 32'(o_matchCount), 32'd5);
    chk("zero_errCount", 32'(o_errCount), 32'd0);

    // reset midway through a burst on a random seed, then relock
    do_reset();
    g0 = $urandom; g1 = $urandom | 32'h1;
    for (int i = 0; i < 5; i++) word(0, 0);
    i_valid = 1'b1; i_data = 32'hDEAD_BEEF;
    do_reset();
    for (int i = 0; i < 5; i++) word(0, 0);
    chk("rerun_matchCount", 32'(o_matchCount), 32'd3);

    // clock gate low: valid words ignored, nothing moves
    gap();
    for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
    chk("cg_matchCount", 32'(o_matchCount), 32'd3);
    word(0, 0);
    chk("cg_resume_matchCount", 32'(o_matchCount), 32'd4);
    chk("cg_resume_error", 32'(o_error), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
